// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, result entry type and index helper for the write-back arbiter
package wb_arbiter_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int RADR_W_DEF = 5;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   res;
        logic [RADR_W_DEF-1:0] rd;
    } wb_entry_t;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin / fixed-priority one-hot arbiter with an internal rotating pointer
//   clk, rst    : clock, asynchronous active-high reset (pointer -> 0)
//   req         : per-requester request vector
//   fixed_prio  : 1 = lowest index wins, 0 = search starts at the pointer and wraps
//   advance     : grant is taken this cycle; pointer moves past the winner
//   grant       : one-hot winner, zero when nothing is requested
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              fixed_prio,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant
);
    localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    logic [PW-1:0]       ptr;
    logic [2*NUM_CH-1:0] rot;
    int                  start;
    int                  sel;

    // Doubling the request vector lets a plain ascending scan handle the wrap.
    always_comb begin
        start = fixed_prio ? 0 : int'(ptr);
        rot   = {req, req} >> start;
        sel   = -1;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (rot[i]) sel = (start + i) % NUM_CH;
        grant = sel >= 0 ? NUM_CH'(1) << sel : '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (advance && sel >= 0) ptr <= PW'(wrap_inc(sel, NUM_CH));
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges NUM_CH result streams through one-entry slots into a registered write-back port
//   clk, rst     : clock, asynchronous active-high reset
//   ch_res_i     : per-channel result, channel k at [k*XLEN +: XLEN]
//   ch_rd_i      : per-channel destination register, channel k at [k*RADR_W +: RADR_W]
//   ch_res_v_i   : per-channel valid
//   ch_ok_o      : per-channel ready (slot empty or draining this cycle)
//   wb_ok_i      : register file ready
//   result_o, rd_o, result_v_o : registered output entry and valid
//   grant_o      : one-hot channel owning the output register
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int NUM_CH     = 2,
    parameter int RADR_W     = RADR_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*XLEN-1:0]   ch_res_i,
    input  logic [NUM_CH*RADR_W-1:0] ch_rd_i,
    input  logic [NUM_CH-1:0]        ch_res_v_i,
    output logic [NUM_CH-1:0]        ch_ok_o,
    input  logic                     wb_ok_i,
    output logic [XLEN-1:0]          result_o,
    output logic [RADR_W-1:0]        rd_o,
    output logic                     result_v_o,
    output logic [NUM_CH-1:0]        grant_o
);
    logic [NUM_CH-1:0] slot_v;
    logic [XLEN-1:0]   slot_res [NUM_CH];
    logic [RADR_W-1:0] slot_rd  [NUM_CH];
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] drain;
    logic [NUM_CH-1:0] take;
    logic [XLEN-1:0]   mux_res;
    logic [RADR_W-1:0] mux_rd;
    logic              can_load;

    assign can_load = !result_v_o || wb_ok_i;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (slot_v),
        .fixed_prio (FIXED_PRIO != 0),
        .advance    (can_load),
        .grant      (grant)
    );

    assign drain   = can_load ? grant : '0;
    assign ch_ok_o = ~slot_v | drain;

    // Writes to x0 are handshaken but never captured.
    always_comb begin
        take    = '0;
        mux_res = '0;
        mux_rd  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            take[k] = ch_res_v_i[k] && ch_ok_o[k] && ch_rd_i[k*RADR_W +: RADR_W] != '0;
            mux_res = mux_res | (grant[k] ? slot_res[k] : '0);
            mux_rd  = mux_rd  | (grant[k] ? slot_rd[k]  : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v     <= '0;
            result_v_o <= 1'b0;
            result_o   <= '0;
            rd_o       <= '0;
            grant_o    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                slot_res[k] <= '0;
                slot_rd[k]  <= '0;
            end
        end else begin
            // A refill takes precedence over the drain so a slot can turn over in one cycle.
            for (int k = 0; k < NUM_CH; k++) begin
                if (take[k]) begin
                    slot_v[k]   <= 1'b1;
                    slot_res[k] <= ch_res_i[k*XLEN +: XLEN];
                    slot_rd[k]  <= ch_rd_i[k*RADR_W +: RADR_W];
                end else if (drain[k]) begin
                    slot_v[k] <= 1'b0;
                end
            end
            if (can_load) begin
                result_v_o <= |drain;
                result_o   <= mux_res;
                rd_o       <= mux_rd;
                grant_o    <= drain;
            end
        end
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Parametrised write-back arbiter that merges result streams from NUM_CH execution units (ALU, MEM, future MUL/DIV, CSR) into the single register-file write port.
- Each channel has a one-entry holding slot, so a producer can hand off a result and retire without waiting for the port.
- Selection is round-robin or fixed-priority, chosen by parameter.
- The output is registered and held under a downstream ready/valid handshake, which the current two-input write-back stage lacks.

Parameters:
XLEN, 32, data width of results.
NUM_CH, 2, number of producer channels (1..8).
RADR_W, 5, register address width.
FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority with channel 0 highest.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ch_res_i  in  NUM_CH*XLEN  per-channel result; channel k occupies bits [k*XLEN +: XLEN].
ch_rd_i  in  NUM_CH*RADR_W  per-channel destination register.
ch_res_v_i  in  NUM_CH  per-channel result valid.
ch_ok_o  out  NUM_CH  per-channel ready; a transfer happens when valid and ready are both high in a cycle.
wb_ok_i  in  1  register file ready to accept the output.
result_o  out  XLEN  selected result.
rd_o  out  RADR_W  selected destination register.
result_v_o  out  1  output valid.
grant_o  out  NUM_CH  one-hot; identifies the channel currently in the output register.

Behaviour:
Reset values:
- Interface is exactly: one clock; reset is asynchronous and active-high (ports clk, rst).
- While rst is high: all slots empty, output register empty, result_v_o=0, result_o=0, rd_o=0, grant_o=0, round-robin pointer=0.
- Reset asserted mid-operation discards all held results; no partial write is emitted.

Slot handshake:
- ch_ok_o[k] = slot k empty OR slot k is being moved into the output register this cycle.
- This is combinational from slot state and the drain decision. It never depends on ch_res_v_i.
- On a transfer with ch_rd_i != 0, slot k captures {res, rd} at the clock edge.
- A transfer with rd = 0 is accepted and dropped: the slot stays empty and nothing reaches the output.

Output register:
- The output register "can load" when it is empty or when wb_ok_i=1.
- When it can load and at least one slot is full, the arbiter picks one full slot, moves it into the output register and clears that slot, all on the same edge.
- If no slot is full, result_v_o drops to 0 after a consumed output.
- While result_v_o=1 and wb_ok_i=0: result_o, rd_o and grant_o are held stable.
- Minimum latency: transfer at edge E0, result_v_o high after edge E1.
- Throughput: one result per cycle when wb_ok_i is held high.

Arbitration:
- FIXED_PRIO=1: the lowest-index full slot wins.
- FIXED_PRIO=0: search starts at the pointer and wraps modulo NUM_CH; the first full slot wins.
- After a grant to channel i, pointer = (i+1) mod NUM_CH. With no grant the pointer is unchanged.
- Pointer wrap-around from NUM_CH-1 to 0 is required.
- In a single cycle a slot can both drain and refill: it is granted, and a new transfer on the same channel is captured.
- NUM_CH=1 degenerates to a 2-deep pipeline.

Ordering:
- Results within one channel leave in arrival order.
- No ordering is guaranteed across channels; register hazards remain the responsibility of register_manager.

Decomposition:
- Shared package: XLEN and RADR_W defaults, and typedef wb_entry_t {logic [XLEN-1:0] res; logic [RADR_W-1:0] rd;}.
- Sub-module rr_arbiter (NUM_CH; inputs req, FIXED_PRIO and advance; outputs one-hot grant; holds the pointer). It is reusable for future issue arbitration.
- Slots and the output register are implemented in the top.

Test Plan:
1. After reset, with wb_ok_i=1: ch0 sends {res=0x11, rd=3} -> result_v_o=1 two edges later, result_o=0x11, rd_o=3, grant_o=01. All ch_ok_o=1 during reset release.
2. Round-robin, NUM_CH=2: both channels send every cycle (ch0 res=0xA0+n, ch1 res=0xB0+n) -> outputs alternate ch0, ch1, ch0 ...; each channel is accepted at 1/2 rate; no value is lost or duplicated.
3. FIXED_PRIO=1 with the same stimulus -> channel 0 gets every grant; ch_ok_o[1] stays low once slot 1 fills; ch1 drains only after ch0 stops.
4. Backpressure: wb_ok_i=0 for 5 cycles while ch0 holds 0x55 -> outputs remain stable. Then: ch0 slot full, output full, ch_ok_o[0]=0. On release, both results appear in order on consecutive cycles.
5. Write to x0: ch1 sends {res=0xDEAD, rd=0} -> ch_ok_o[1]=1, result_v_o never asserts for it.
6. Reset mid-stream: assert rst while both slots and the output are full -> result_v_o and grant_o go to 0 immediately (asynchronously), and no stale value appears after release.
